map_merger: RTL
===============

Name: map_merger

Overview:
- Downstream stage of the psum accumulator. Consumes fully accumulated 64-bit psum words, each holding two signed 32-bit lanes.
- Per lane, in order: adds a bias, applies optional ReLU, requantizes to int8 with a rounding arithmetic right shift and saturation.
- Packs 4 input beats (8 int8 results) into one 64-bit output feature-map word. Emits each word with a running write address toward the writeback/output buffer.
- Runs one tile per cfg_start and pulses done when the tile's last word is accepted downstream.

Parameters:
- ADDR_W, 32, width of output address.
- CNT_W, 16, width of the per-tile output word count.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous active-high reset.
- cfg_start  input  1  one-cycle pulse; latches cfg_* and begins a tile.
- cfg_base_addr  input  ADDR_W  byte address of the tile's first output word.
- cfg_out_words  input  CNT_W  output words per tile; 0 is treated as 1.
- cfg_bias_lo  input  32  signed bias for lane 0 (data[31:0]).
- cfg_bias_hi  input  32  signed bias for lane 1 (data[63:32]).
- cfg_shift  input  5  requant right-shift amount, 0..31.
- cfg_relu_en  input  1  clamp negative values to 0 after the bias add.
- psum_acc2map_merger_data  input  64  two signed 32-bit psums.
- psum_acc2map_merger_vld  input  1  input valid.
- psum_acc2map_merger_rdy  output  1  input ready.
- map_merger2wb_data  output  64  packed int8 word.
- map_merger2wb_addr  output  ADDR_W  byte address of the word.
- map_merger2wb_last  output  1  final word of the tile.
- map_merger2wb_vld  output  1  output valid.
- map_merger2wb_rdy  input  1  output ready.
- done  output  1  one-cycle pulse after the last word handshake.

Behaviour:
- Reset values: all outputs 0; state IDLE; beat_cnt=0; word_idx=0; output register empty.
- IDLE:
  - psum_acc2map_merger_rdy=0.
  - cfg_start: latch all cfg_* into shadow registers, addr_cnt=cfg_base_addr, enter RUN next cycle.
- RUN: an input beat is accepted on vld&rdy.
- Lane math (combinational on input), per lane:
  - s = sext33(psum) + sext33(bias).
  - If relu_en and s<0, s=0.
  - If shift>0: r = (s + 2^(shift-1)) >>> shift, with the add in 34 bits. If shift=0: r = s.
  - q = saturate(r, -128, 127).
- Packing:
  - Beat k (k = beat_cnt, 0..3) places lane0 q at byte 2k and lane1 q at byte 2k+1. Byte 0 is [7:0].
  - Beats 0..2 write the pack buffer.
  - Beat 3 loads the full word (pack buffer + current beat) into the output register. vld rises the next cycle: 1-cycle latency from the 4th input handshake.
- Input ready in RUN: rdy = (beat_cnt != 3) | ~map_merger2wb_vld | map_merger2wb_rdy. Beats 0..2 are accepted even while the output is stalled.
- Output:
  - vld stays high until rdy; data, addr and last are held stable while vld & ~rdy.
  - addr = addr_cnt at load time; addr_cnt += 8 per loaded word, wrapping modulo 2^ADDR_W.
  - last = 1 when word_idx == out_words-1.
- Tile end: on the handshake of the last word, done=1 for one cycle and state returns to IDLE. A new cfg_start is accepted the following cycle. beat_cnt and word_idx return to 0.
- Simultaneous events:
  - cfg_start while in RUN is ignored.
  - cfg_start in the same cycle as the last-word handshake is ignored; the upstream issues it after done.
  - Output load and output handshake in the same cycle: the new word replaces the old one, vld stays 1.
- Reset mid-tile: synchronous; discards the pack buffer and output word, vld drops the next cycle, no done pulse.
- Input beats arriving in IDLE are not accepted (rdy=0); upstream holds them.

Decomposition:
- Package map_merger_pkg holds: LANES=2, LANE_W=32, Q_W=8, BEATS_PER_WORD=4, ADDR_STEP=8, state encodings IDLE/RUN, and the saturation bounds.
- One natural sub-module, map_merger_requant: combinational bias/ReLU/round-shift/saturate for one lane, instantiated twice.

Test Plan:
- Basic tile:
  - Stimulus: bias 0, shift 0, relu off, out_words=1, base 0x100; beats (lo,hi) = (1,2), (3,4), (5,6), (7,8).
  - Response: data=0x0807060504030201, addr=0x100, last=1, one cycle after the 4th beat; done one cycle after the handshake.
- Rounding/saturation:
  - Stimulus: shift 4, bias_lo 8; lo psums 24, -24, 5000, -5000.
  - Response: lane0 bytes = 2, -1 (0xFF), 127, -128 (0x80).
- ReLU:
  - Stimulus: relu_en=1, bias_hi -10, hi psum 5.
  - Response: hi byte 0. With relu_en=0 the same input gives 0xFB.
- Backpressure:
  - Stimulus: out_words=3, wb_rdy held 0 after the first word.
  - Response: word 0 held stable; 3 further beats accepted; rdy=0 on the 4th beat until wb_rdy=1; addresses 0x100, 0x108, 0x110; last only on word 2.
- Control:
  - Stimulus: cfg_start during RUN.
  - Response: ignored, tile completes normally.
  - Stimulus: rst asserted after 2 beats, then a new cfg_start.
  - Response: vld=0, no done pulse, next tile packs from byte 0.
- Address wrap:
  - Stimulus: base 0xFFFF_FFF8, out_words=2.
  - Response: addrs 0xFFFF_FFF8, then 0x0000_0000.

Source files
------------

// File: rtl/map_merger_pkg.sv
// Shared constants and types for the psum-to-feature-map merge stage.
package map_merger_pkg;

    localparam int LANES          = 2;
    localparam int LANE_W         = 32;
    localparam int Q_W            = 8;
    localparam int BEATS_PER_WORD = 4;
    localparam int ADDR_STEP      = 8;

    localparam int SAT_MAX = 127;
    localparam int SAT_MIN = -128;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    // Per-tile requant settings latched on cfg_start.
    typedef struct packed {
        logic [LANES-1:0][LANE_W-1:0] bias;
        logic [4:0]                   shift;
        logic                         relu_en;
    } lane_cfg_t;

endpackage

// File: rtl/map_merger_requant.sv
// One lane of bias add, optional ReLU, round-half-up arithmetic shift and int8 saturation.
module map_merger_requant
    import map_merger_pkg::*;
(
    input  logic [LANE_W-1:0] psum,
    input  logic [LANE_W-1:0] bias,
    input  logic [4:0]        shift,
    input  logic              relu_en,
    output logic [Q_W-1:0]    q
);

    logic signed [LANE_W:0]   sum;
    logic signed [LANE_W:0]   act;
    logic signed [LANE_W+1:0] rnd;
    logic signed [LANE_W+1:0] res;

    always_comb begin
        sum = $signed({psum[LANE_W-1], psum}) + $signed({bias[LANE_W-1], bias});
        act = (relu_en && sum[LANE_W]) ? '0 : sum;
        // With shift=0 the rounding term is zero and the shift is a no-op, so r = s falls out.
        rnd = '0;
        if (shift != 5'd0) rnd[shift - 5'd1] = 1'b1;
        res = ($signed({act[LANE_W], act}) + rnd) >>> shift;
        if (res > (LANE_W+2)'(SAT_MAX))      q = Q_W'(SAT_MAX);
        else if (res < (LANE_W+2)'(SAT_MIN)) q = Q_W'(SAT_MIN);
        else                                 q = res[Q_W-1:0];
    end

endmodule

// File: rtl/map_merger.sv
// Requantizes two-lane psum beats to int8, packs four beats per 64-bit word and streams
// the words with running byte addresses, one tile per cfg_start.
module map_merger
    import map_merger_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_start,
    input  logic [ADDR_W-1:0] cfg_base_addr,
    input  logic [CNT_W-1:0]  cfg_out_words,
    input  logic [31:0]       cfg_bias_lo,
    input  logic [31:0]       cfg_bias_hi,
    input  logic [4:0]        cfg_shift,
    input  logic              cfg_relu_en,
    input  logic [63:0]       psum_acc2map_merger_data,
    input  logic              psum_acc2map_merger_vld,
    output logic              psum_acc2map_merger_rdy,
    output logic [63:0]       map_merger2wb_data,
    output logic [ADDR_W-1:0] map_merger2wb_addr,
    output logic              map_merger2wb_last,
    output logic              map_merger2wb_vld,
    input  logic              map_merger2wb_rdy,
    output logic              done
);

    logic [0:0]        state_q, state_d;
    logic [1:0]        beat_cnt_q, beat_cnt_d;
    logic [CNT_W-1:0]  word_idx_q, word_idx_d;
    logic [CNT_W-1:0]  out_words_q, out_words_d;
    logic [ADDR_W-1:0] addr_cnt_q, addr_cnt_d;
    lane_cfg_t         cfg_q, cfg_d;
    logic [BEATS_PER_WORD-2:0][LANES*Q_W-1:0] pack_q, pack_d;
    logic [63:0]       out_data_q, out_data_d;
    logic [ADDR_W-1:0] out_addr_q, out_addr_d;
    logic              out_last_q, out_last_d;
    logic              out_vld_q, out_vld_d;
    logic              done_q, done_d;

    logic [LANES-1:0][LANE_W-1:0] psum_lane;
    logic [LANES-1:0][Q_W-1:0]    q_lane;
    logic in_rdy, in_fire, out_fire;

    assign psum_lane = psum_acc2map_merger_data;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        map_merger_requant u_requant (
            .psum    (psum_lane[g]),
            .bias    (cfg_q.bias[g]),
            .shift   (cfg_q.shift),
            .relu_en (cfg_q.relu_en),
            .q       (q_lane[g])
        );
    end

    // Only the word-completing beat needs the output register free.
    assign in_rdy   = (state_q == ST_RUN) &&
                      ((beat_cnt_q != 2'd3) || !out_vld_q || map_merger2wb_rdy);
    assign in_fire  = in_rdy && psum_acc2map_merger_vld;
    assign out_fire = out_vld_q && map_merger2wb_rdy;

    always_comb begin
        state_d     = state_q;
        beat_cnt_d  = beat_cnt_q;
        word_idx_d  = word_idx_q;
        out_words_d = out_words_q;
        addr_cnt_d  = addr_cnt_q;
        cfg_d       = cfg_q;
        pack_d      = pack_q;
        out_data_d  = out_data_q;
        out_addr_d  = out_addr_q;
        out_last_d  = out_last_q;
        out_vld_d   = out_vld_q;
        done_d      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cfg_start) begin
                    cfg_d.bias    = {cfg_bias_hi, cfg_bias_lo};
                    cfg_d.shift   = cfg_shift;
                    cfg_d.relu_en = cfg_relu_en;
                    out_words_d   = (cfg_out_words == '0) ? CNT_W'(1) : cfg_out_words;
                    addr_cnt_d    = cfg_base_addr;
                    state_d       = ST_RUN;
                end
            end
            default: begin
                if (out_fire) out_vld_d = 1'b0;
                // A load in the same cycle as a handshake overrides the clear above.
                if (in_fire) begin
                    case (beat_cnt_q)
                        2'd0: pack_d[0] = q_lane;
                        2'd1: pack_d[1] = q_lane;
                        2'd2: pack_d[2] = q_lane;
                        default: begin
                            out_data_d = {q_lane, pack_q};
                            out_addr_d = addr_cnt_q;
                            out_last_d = (word_idx_q == out_words_q - CNT_W'(1));
                            out_vld_d  = 1'b1;
                            addr_cnt_d = addr_cnt_q + ADDR_W'(ADDR_STEP);
                            word_idx_d = word_idx_q + CNT_W'(1);
                        end
                    endcase
                    beat_cnt_d = beat_cnt_q + 2'd1;
                end
                if (out_fire && out_last_q) begin
                    done_d     = 1'b1;
                    state_d    = ST_IDLE;
                    beat_cnt_d = '0;
                    word_idx_d = '0;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            beat_cnt_q  <= '0;
            word_idx_q  <= '0;
            out_words_q <= '0;
            addr_cnt_q  <= '0;
            cfg_q       <= '0;
            pack_q      <= '0;
            out_data_q  <= '0;
            out_addr_q  <= '0;
            out_last_q  <= 1'b0;
            out_vld_q   <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            beat_cnt_q  <= beat_cnt_d;
            word_idx_q  <= word_idx_d;
            out_words_q <= out_words_d;
            addr_cnt_q  <= addr_cnt_d;
            cfg_q       <= cfg_d;
            pack_q      <= pack_d;
            out_data_q  <= out_data_d;
            out_addr_q  <= out_addr_d;
            out_last_q  <= out_last_d;
            out_vld_q   <= out_vld_d;
            done_q      <= done_d;
        end
    end

    assign psum_acc2map_merger_rdy = in_rdy;
    assign map_merger2wb_data      = out_data_q;
    assign map_merger2wb_addr      = out_addr_q;
    assign map_merger2wb_last      = out_last_q;
    assign map_merger2wb_vld       = out_vld_q;
    assign done                    = done_q;

endmodule
